// File: rtl/simd_mem_pkg.sv
// Shared types and line/word geometry for the SIMD line-to-word memory bridge.
package simd_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  localparam int LINE_WORDS  = 8;
  localparam int LINE_BITS   = 256;
  localparam int LINE_ADDR_W = 14;
  localparam int WORD_ADDR_W = 17;
  localparam int BE_LINE_W   = 32;
  localparam int WORD_W      = 32;
  localparam int BEAT_W      = 3;

endpackage

// File: rtl/simd_mem_bridge_if.sv
// Processor-side line port plus memory-side word port of the bridge.
interface simd_mem_bridge_if;
  import simd_mem_pkg::*;

  logic [LINE_ADDR_W-1:0] address_RAM;
  logic [BE_LINE_W-1:0]   byteena_RAM;
  logic [LINE_BITS-1:0]   writeData_RAM;
  logic                   rden_RAM;
  logic                   wren_RAM;
  logic [LINE_BITS-1:0]   readData_RAM;
  logic                   mem_stall;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0]      mem_wdata;
  logic [3:0]             mem_byteen;
  logic                   mem_wren;
  logic                   mem_rden;
  logic [WORD_W-1:0]      mem_rdata;

  modport slave (
    input  address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM, mem_rdata,
    output readData_RAM, mem_stall, mem_addr, mem_wdata, mem_byteen, mem_wren, mem_rden
  );

  modport master (
    output address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM, mem_rdata,
    input  readData_RAM, mem_stall, mem_addr, mem_wdata, mem_byteen, mem_wren, mem_rden
  );

endinterface

// File: rtl/mem_ret_pipe.sv
// Delays {valid, beat index} of each issued read by the memory latency so the
// returning word can be steered into the right slot of the line buffer.
module mem_ret_pipe
  import simd_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_idx,
  output logic              ret_we,
  output logic [BEAT_W-1:0] ret_idx
);

  logic [READ_LATENCY-1:0]             valid_q, valid_d;
  logic [READ_LATENCY-1:0][BEAT_W-1:0] idx_q, idx_d;

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    valid_d[0] = in_valid;
    idx_d[0]   = in_idx;
    for (int i = 1; i < READ_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      idx_d[i]   = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign ret_we  = valid_q[READ_LATENCY-1];
  assign ret_idx = idx_q[READ_LATENCY-1];

endmodule

// File: rtl/simd_mem_bridge.sv
// Splits 256-bit line reads/writes into eight 32-bit word beats, stalling the
// processor until the whole line has been transferred.
module simd_mem_bridge
  import simd_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  simd_mem_bridge_if.slave   bus
);

  mem_state_t             state_q, state_d;
  logic [BEAT_W:0]        issue_q, issue_d;
  logic [BEAT_W-1:0]      ret_q, ret_d;
  logic [LINE_ADDR_W-1:0] line_q, line_d;
  logic [BE_LINE_W-1:0]   be_q, be_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   buf_q, buf_d;
  logic [LINE_BITS-1:0]   rdline_q, rdline_d;

  logic                   stall_c;
  logic [WORD_ADDR_W-1:0] addr_c;
  logic [WORD_W-1:0]      wdata_c;
  logic [3:0]             byteen_c;
  logic                   wren_c;
  logic                   rden_c;
  logic                   ret_we;
  logic [BEAT_W-1:0]      ret_idx;

  mem_ret_pipe #(.READ_LATENCY(READ_LATENCY)) u_ret_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rden_c),
    .in_idx   (issue_q[BEAT_W-1:0]),
    .ret_we   (ret_we),
    .ret_idx  (ret_idx)
  );

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    ret_d    = ret_q;
    line_d   = line_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdline_d = rdline_q;
    stall_c  = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    byteen_c = '0;
    wren_c   = 1'b0;
    rden_c   = 1'b0;

    case (state_q)
      IDLE: begin
        issue_d = '0;
        ret_d   = '0;
        // A write takes priority; a simultaneous read strobe is discarded.
        if (bus.wren_RAM) begin
          stall_c = 1'b1;
          line_d  = bus.address_RAM;
          be_d    = bus.byteena_RAM;
          wdata_d = bus.writeData_RAM;
          state_d = WRITE;
        end else if (bus.rden_RAM) begin
          stall_c = 1'b1;
          line_d  = bus.address_RAM;
          state_d = READ;
        end
      end
      WRITE: begin
        stall_c  = 1'b1;
        addr_c   = {line_q, issue_q[BEAT_W-1:0]};
        wdata_c  = wdata_q[{issue_q[BEAT_W-1:0], 5'd0} +: WORD_W];
        byteen_c = be_q[{issue_q[BEAT_W-1:0], 2'd0} +: 4];
        // Empty beats still take their slot so write latency never varies.
        wren_c   = |byteen_c;
        issue_d  = issue_q + 1'b1;
        if (issue_q[BEAT_W-1:0] == 3'd7) state_d = DONE;
      end
      READ: begin
        stall_c = 1'b1;
        if (!issue_q[BEAT_W]) begin
          rden_c  = 1'b1;
          addr_c  = {line_q, issue_q[BEAT_W-1:0]};
          issue_d = issue_q + 1'b1;
        end
        if (ret_we) begin
          buf_d[{ret_idx, 5'd0} +: WORD_W] = bus.mem_rdata;
          ret_d = ret_q + 1'b1;
          // Publish the line only once complete so readData_RAM never shows a mix.
          if (ret_q == 3'd7) begin
            rdline_d = buf_d;
            state_d  = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      issue_q  <= '0;
      ret_q    <= '0;
      line_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdline_q <= '0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      ret_q    <= ret_d;
      line_q   <= line_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdline_q <= rdline_d;
    end
  end

  assign bus.readData_RAM = rdline_q;
  assign bus.mem_stall    = stall_c;
  assign bus.mem_addr     = addr_c;
  assign bus.mem_wdata    = wdata_c;
  assign bus.mem_byteen   = byteen_c;
  assign bus.mem_wren     = wren_c;
  assign bus.mem_rden     = rden_c;

endmodule

// File: tb/tb_simd_mem_bridge.sv
// Directed scoreboard bench: two bridges (read latency 1 and 3) share stimulus,
// each backed by a memory model that returns word = address.
module tb_simd_mem_bridge;

  typedef struct packed {
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        w;
    logic        r;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [13:0]  addr_r = '0;
  logic [31:0]  be_r = '0;
  logic [255:0] data_r = '0;
  logic         rden1 = 1'b0, wren1 = 1'b0, rden3 = 1'b0, wren3 = 1'b0;
  logic [31:0]  m1, m3a, m3b, m3c;

  int vectors = 0;
  int miscompares = 0;

  beat_t        beat_q[$];
  logic [255:0] lq1[$];
  logic [255:0] lq3[$];
  logic [255:0] rd_model = '0;
  logic [255:0] wline;

  simd_mem_bridge_if b1 ();
  simd_mem_bridge_if b3 ();

  simd_mem_bridge #(.READ_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  simd_mem_bridge #(.READ_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  always #5 clk = ~clk;

  assign b1.address_RAM   = addr_r;
  assign b1.byteena_RAM   = be_r;
  assign b1.writeData_RAM = data_r;
  assign b1.rden_RAM      = rden1;
  assign b1.wren_RAM      = wren1;
  assign b3.address_RAM   = addr_r;
  assign b3.byteena_RAM   = be_r;
  assign b3.writeData_RAM = data_r;
  assign b3.rden_RAM      = rden3;
  assign b3.wren_RAM      = wren3;

  // Memory models: read data appears READ_LATENCY cycles after mem_rden.
  always @(posedge clk) begin
    m1  <= b1.mem_rden ? {15'd0, b1.mem_addr} : 32'hDEAD_BEEF;
    m3a <= b3.mem_rden ? {15'd0, b3.mem_addr} : 32'hDEAD_BEEF;
    m3b <= m3a;
    m3c <= m3b;
  end
  assign b1.mem_rdata = m1;
  assign b3.mem_rdata = m3c;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic rd, input logic [13:0] line,
                         input logic [31:0] be, input logic [255:0] data, input int abort_at);
    beat_t b;
    bit    act1, act3;
    int    exp1, exp3;
    exp1 = wr ? 9 : 10;
    exp3 = wr ? 9 : 12;
    for (int k = 0; k < 8; k++) begin
      b.a = {line, 3'(k)};
      b.d = wr ? data[32*k +: 32] : 32'd0;
      b.b = wr ? be[4*k +: 4] : 4'd0;
      b.w = wr && (be[4*k +: 4] != 4'd0);
      b.r = !wr;
      beat_q.push_back(b);
    end
    if (!wr && rd)
      for (int k = 0; k < 8; k++) rd_model[32*k +: 32] = {15'd0, line, 3'(k)};
    lq1.push_back(rd_model);
    lq3.push_back(rd_model);

    @(negedge clk);
    addr_r = line; be_r = be; data_r = data;
    wren1 = wr; rden1 = rd; wren3 = wr; rden3 = rd;
    act1 = 1'b1; act3 = 1'b1;
    for (int c = 0; c < 40 && (act1 || act3); c++) begin
      #1;
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_stall_live", 256'(b1.mem_stall), 256'(1));
        wren1 = 0; rden1 = 0; wren3 = 0; rden3 = 0;
        #1;
        chk("rst_stall1", 256'(b1.mem_stall), 256'(0));
        chk("rst_rden1", 256'(b1.mem_rden), 256'(0));
        chk("rst_addr1", 256'(b1.mem_addr), 256'(0));
        chk("rst_rdata1", b1.readData_RAM, 256'(0));
        chk("rst_rdata3", b3.readData_RAM, 256'(0));
        beat_q.delete(); lq1.delete(); lq3.delete();
        rd_model = '0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (act1 && c >= 1 && c <= 8 && beat_q.size() != 0) begin
        b = beat_q.pop_front();
        chk($sformatf("addr%0d", c), 256'(b1.mem_addr), 256'(b.a));
        chk($sformatf("wdata%0d", c), 256'(b1.mem_wdata), 256'(b.d));
        chk($sformatf("byteen%0d", c), 256'(b1.mem_byteen), 256'(b.b));
        chk($sformatf("wren%0d", c), 256'(b1.mem_wren), 256'(b.w));
        chk($sformatf("rden%0d", c), 256'(b1.mem_rden), 256'(b.r));
      end
      if (act1 && !b1.mem_stall) begin
        chk("stall_cycles1", 256'(c), 256'(exp1));
        chk("strobes_done1", 256'({b1.mem_wren, b1.mem_rden}), 256'(0));
        chk("readData1", b1.readData_RAM, lq1.pop_front());
        wren1 = 0; rden1 = 0; act1 = 1'b0;
      end
      if (act3 && !b3.mem_stall) begin
        chk("stall_cycles3", 256'(c), 256'(exp3));
        chk("readData3", b3.readData_RAM, lq3.pop_front());
        wren3 = 0; rden3 = 0; act3 = 1'b0;
      end
      @(negedge clk);
    end
    chk("finished1", 256'(act1), 256'(0));
    chk("finished3", 256'(act3), 256'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", 256'(b1.mem_stall), 256'(0));
    chk("reset_addr", 256'(b1.mem_addr), 256'(0));
    chk("reset_wdata", 256'(b1.mem_wdata), 256'(0));
    chk("reset_byteen", 256'(b1.mem_byteen), 256'(0));
    chk("reset_strobes", 256'({b1.mem_wren, b1.mem_rden}), 256'(0));
    chk("reset_rdata1", b1.readData_RAM, 256'(0));
    chk("reset_rdata3", b3.readData_RAM, 256'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) wline[32*k +: 32] = 32'hA000_0000 + 32'(k);
    $display("step: full write line 0x0005");
    run_req(1'b1, 1'b0, 14'h0005, 32'hFFFF_FFFF, wline, -1);
    $display("step: sparse write line 0x0006 be=0000F00F");
    run_req(1'b1, 1'b0, 14'h0006, 32'h0000_F00F, ~wline, -1);
    $display("step: read line 0x3FFF");
    run_req(1'b0, 1'b1, 14'h3FFF, 32'h0, 256'h0, -1);
    $display("step: simultaneous strobes line 0x0001");
    run_req(1'b1, 1'b1, 14'h0001, 32'hFFFF_FFFF, wline ^ {8{32'h5555_AAAA}}, -1);
    $display("step: read line 0x0010 reset at cycle 4");
    run_req(1'b0, 1'b1, 14'h0010, 32'h0, 256'h0, 4);
    $display("step: read line 0x0123 after reset");
    run_req(1'b0, 1'b1, 14'h0123, 32'h0, 256'h0, -1);
    $display("step: back-to-back read line 0x2AAA");
    run_req(1'b0, 1'b1, 14'h2AAA, 32'h0, 256'h0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simd_mem_bridge.md
# simd_mem_bridge

Bridges the SIMD processor's 256-bit vector RAM port to a 32-bit word-addressed on-chip memory. Each line access is split into eight 32-bit beats. The processor is held via a stall output until the line completes. The bridge sits directly downstream of the processor's memory stage, and its `mem_stall` output is OR-ed into the pipeline stall network.

## Interface
- `READ_LATENCY`, 1: memory read latency in cycles, legal range 1–4.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `address_RAM`  in  14  line address.
- `byteena_RAM`  in  32  byte enables; bit b covers `writeData_RAM[8b+7:8b]`.
- `writeData_RAM`  in  256  write line.
- `rden_RAM`, `wren_RAM`  in  1 each  request strobes; held stable by the processor while `mem_stall`=1.
- `readData_RAM`  out  256  last completed read line.
- `mem_stall`  out  1  request in progress.
- `mem_addr`  out  17  word address = {line, beat[2:0]}.
- `mem_wdata`  out  32  write word.
- `mem_byteen`  out  4  byte enables for the word.
- `mem_wren`, `mem_rden`  out  1 each  memory strobes.
- `mem_rdata`  in  32  read word, valid `READ_LATENCY` cycles after `mem_rden`.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- **IDLE**
  - `wren_RAM`=1: latch address, byte enables and data; go to WRITE.
  - Else `rden_RAM`=1: latch address; go to READ.
  - Both strobes high: write wins; the read is dropped.
- **WRITE**, 8 cycles, beat k=0..7:
  - `mem_addr`={line,k}, `mem_wdata`=data[32k+31:32k], `mem_byteen`=be[4k+3:4k].
  - `mem_wren`=1 only if that nibble is nonzero. All-zero beats still consume their cycle, so latency is fixed.
  - Go to DONE after beat 7.
- **READ**
  - Issue beats 0..7 on consecutive cycles with `mem_rden`=1.
  - A `READ_LATENCY`-deep valid/index shift pipe tags each return. Return beat k is written to line buffer word k.
  - Go to DONE when the 8th return has been captured.
- **DONE**: one cycle. After a read, `readData_RAM` shows the new line. Return to IDLE.
- `mem_stall` = (IDLE and (`rden_RAM` or `wren_RAM`)) or WRITE or READ. It is combinational and low in DONE, so the pipeline advances on the DONE edge.
- `readData_RAM` holds its value until the next read's DONE. Writes never modify it.
- Memory strobes are 0 outside WRITE/READ.
- Addresses: no wrap logic. Line 0x3FFF maps to words 0x1FFF8–0x1FFFF.

## Timing
- Request visible in IDLE at cycle 0.
- Write:
  - Beats on cycles 1–8.
  - DONE at cycle 9.
  - Stall high cycles 0–8 (9 cycles).
- Read:
  - Beats issued cycles 1–8; returns sampled cycles 1+k+`READ_LATENCY`.
  - DONE at cycle 9+`READ_LATENCY`.
  - Stall is 9+`READ_LATENCY` cycles (10 at default).
- Back-to-back: a new request is recognised in the IDLE cycle after DONE. Minimum spacing is one DONE plus one IDLE cycle.
- Reset, asynchronous and valid at any time including mid-burst:
  - State goes to IDLE; beat/return counters and the latency pipe clear.
  - `readData_RAM`=0, latched request cleared.
  - All `mem_*` outputs 0; `mem_stall` follows only the live request inputs.
  - A partially written line stays partially written in memory. No recovery is attempted.
- Request strobes changing while busy is a protocol violation. The latched copy is used regardless.

## Structure
- Package `simd_mem_pkg` holds:
  - the state enum `mem_state_t`;
  - constants `LINE_WORDS`=8, `LINE_BITS`=256, `LINE_ADDR_W`=14, `WORD_ADDR_W`=17, `BE_LINE_W`=32.
- Sub-module `mem_ret_pipe`:
  - parameterised `READ_LATENCY`-deep shift of {valid, beat index};
  - emits the write-enable and word index for the line buffer.
- Top holds the FSM, issue counter, return counter, request latches and the 256-bit line buffer.

## Test plan
- **Reset:** assert `reset` with inputs idle → all outputs 0, `readData_RAM`=0.
- **Full write:** `wren_RAM`, line 0x0005, be=0xFFFFFFFF, data word k = 0xA0000000+k → `mem_addr` 0x00028..0x0002F on cycles 1–8, `mem_byteen`=0xF, stall 9 cycles, DONE at cycle 9.
- **Sparse write:** be=0x0000F00F → `mem_wren` high only on beats 0 and 3 with `mem_byteen` 0xF and 0xF, other beats `mem_wren`=0. Latency is still 9.
- **Read:** memory model returns word = address; read line 0x3FFF at `READ_LATENCY`=1 and 3 → `readData_RAM` word k = 0x1FFF8+k, stall 10 and 12 cycles respectively.
- **Simultaneous strobes:** `rden_RAM`=`wren_RAM`=1 → only write beats issued, `mem_rden` never high, `readData_RAM` unchanged.
- **Mid-read reset:** reset at read cycle 4 → next cycle IDLE, counters 0, `readData_RAM`=0. A following read completes with correct data.
